// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS data (LSB first), optional parity, stop bits, idle gap.
// Parity is compiled in with `define UART_TX_PARITY_EN; the default build has no parity state or logic.
`timescale 1ns/1ps
module uart_tx_frame #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int IDLE_BITS  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 RST_clk,
  input  logic                 RST_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_tx_data,
  output logic                 uart_busy,
  output logic                 tx_done
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (IDLE_BITS < 0 || IDLE_BITS > 255 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_misc
    $error("uart_tx_frame: IDLE_BITS must be 0..255 and PARITY_ODD 0 or 1");
  end

  localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [7:0]        GAP_LAST  = 8'(IDLE_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_e;
`endif

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic [7:0]            gap_q, gap_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  always_ff @(posedge RST_clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    tx_done = 1'b0;
    bit_end = (baud_q == BAUD_LAST);
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d = S_START;
          shift_d = tx_data;
          baud_d  = '0;
          bit_d   = '0;
          gap_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
            bit_d = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (IDLE_BITS > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              state_d = S_IDLE;
              tx_done = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (gap_q == GAP_LAST) begin
            state_d = S_IDLE;
            gap_d   = '0;
            tx_done = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level decodes straight from state so an async reset forces it high immediately.
  always_comb begin
    uart_tx_data = 1'b1;
    case (state_q)
      S_START:  uart_tx_data = 1'b0;
      S_DATA:   uart_tx_data = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: uart_tx_data = par_q;
`endif
      default:  uart_tx_data = 1'b1;
    endcase
  end

  assign tx_ready  = (state_q == S_IDLE);
  assign uart_busy = (state_q != S_IDLE);

endmodule
